// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch path: widths, opcode field, fetch entry, fetch FSM states.
package isa_pkg;

  localparam int ADDR_W = 5;
  localparam int INST_W = 16;

  // Opcode field position inside an instruction word.
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 13;
  localparam logic [OP_MSB-OP_LSB:0] OP_HALT = 3'b111;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  // True when the instruction word carries the HALT opcode.
  function automatic logic is_halt(input logic [INST_W-1:0] inst);
    return inst[OP_MSB:OP_LSB] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetch entries between the PC/ROM side and decode.
// The caller guarantees no push when full and no pop when empty; flush empties it.
module fetch_buffer
  import isa_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two entries are reset on purpose so head (and hence out_inst/out_pc)
      // reads as zero after reset; larger memories would normally be left unreset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, RUN/HALTED control, redirect handling,
// and a two-entry buffer delivering {pc, inst} to decode over valid/ready.
module instruction_fetch #(
  parameter int                ADDR_W   = isa_pkg::ADDR_W,
  parameter int                INST_W   = isa_pkg::INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  import isa_pkg::fetch_entry_t;
  import isa_pkg::fetch_state_e;
  import isa_pkg::RUN;
  import isa_pkg::HALTED;
  import isa_pkg::is_halt;

  logic [ADDR_W-1:0] pc;
  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [1:0]        count;
  fetch_entry_t      head;
  fetch_entry_t      din;
  logic              push;
  logic              pop;

  // Push uses only registered state so the ROM address never waits on out_ready.
  // Redirect suppresses both push and pop; the flush discards everything anyway.
  assign push = (state == RUN) && (count != 2'd2) && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;
  assign din  = '{pc: pc, inst: imem_inst};

  fetch_buffer u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .count (count),
    .head  (head)
  );

  // Program counter: redirect target, else advance (wrapping) on each push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (push) begin
      // NOTE: non-blocking assignment keeps this flop's update ordered with every
      // other flop sampling pc on the same edge.
      pc <= pc + 1'b1;
    end
  end

  // Fetch state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: redirect always restarts; pushing a HALT word stops fetching.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    if (redirect_valid) begin
      state_next = RUN;
    end else if (push && is_halt(imem_inst)) begin
      state_next = HALTED;
    end
  end

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;
  assign halted    = (state == HALTED);

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage: owns the program counter, drives the address of the combinational 32 x 16-bit instruction ROM, and delivers `{pc, inst}` pairs to the decode stage over a valid/ready handshake. It sits between the instruction ROM and decode. It buffers up to two fetched words so the ROM address never depends combinationally on downstream ready, accepts PC redirects from execute, and stops fetching after a HALT instruction.

## Interface
- `ADDR_W`, default 5: PC / ROM address width (32 words).
- `INST_W`, default 16: instruction width.
- `RESET_PC`, default 0: PC value loaded by reset.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `imem_addr`  out  ADDR_W  ROM read address; equals the PC register.
- `imem_inst`  in  INST_W  ROM read data; combinational from `imem_addr` in the same cycle.
- `redirect_valid`  in  1  load a new PC and flush buffered instructions.
- `redirect_pc`  in  ADDR_W  target PC, sampled when `redirect_valid`=1.
- `out_valid`  out  1  buffer head holds a fetched instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_inst`  out  INST_W  head instruction.
- `out_pc`  out  ADDR_W  address the head instruction was fetched from.
- `halted`  out  1  fetch is in HALTED state.

## Operation
- Instruction fields: opcode `[15:13]`; HALT is opcode `3'b111`. The fetch stage decodes no other field.
- States:
  - RUN: fetch when enabled.
  - HALTED: never fetch.
- Push condition is `state==RUN && count!=2`, using the registered count only. On push:
  - The entry `{pc, imem_inst}` is written to the buffer tail.
  - `pc <= pc+1`, mod 2^ADDR_W, so 31 wraps to 0.
- Pop condition is `out_valid && out_ready`. It removes the head entry.
- Push and pop in the same cycle leave `count` unchanged, and FIFO order is preserved.
- If a pushed instruction has opcode 111, the state moves RUN to HALTED after that push. The HALT word itself is still delivered. Once drained, `out_valid` stays 0.
- Redirect (`redirect_valid`=1) takes priority over push and pop:
  - `pc <= redirect_pc`, `count <= 0`, state moves to RUN, including from HALTED.
  - No push occurs that cycle.
  - A handshake on the same cycle still counts as completed for the consumer; the entry is discarded either way.
- Reset values:
  - `pc = RESET_PC`, so `imem_addr = RESET_PC`.
  - `count = 0`, `out_valid = 0`.
  - Both entries are zero, so `out_inst = 0` and `out_pc = 0`.
  - State = RUN, `halted = 0`.
- Assertion of `rst_n` mid-operation clears all state immediately, without waiting for a clock edge. Any in-flight entries are lost.
- `out_inst` and `out_pc` are valid only when `out_valid`=1, and they hold stable while `out_valid && !out_ready`.

## Timing
- ROM access is combinational. The word at `pc` is captured at the end of the same cycle.
- Fetch-to-output latency is 1 cycle. On the first edge after `rst_n` deasserts, `out_valid=1` and `out_pc=RESET_PC`.
- With `out_ready` held at 1, throughput is 1 instruction/cycle and `count` stays at 1.
- With `out_ready`=0, the buffer fills in 2 cycles and the PC then freezes. When ready returns, output resumes with no bubble.
- Redirect: the first target instruction appears on `out_*` 1 cycle after the redirect edge. Exactly one bubble cycle is seen by decode.
- `halted` rises on the edge that pushes the HALT word.
- No output is a combinational function of `out_ready` or `redirect_valid`.

## Structure
- Shared package `isa_pkg` holds:
  - `ADDR_W` and `INST_W` constants.
  - Opcode field position constants and `OP_HALT = 3'b111`.
  - `fetch_entry_t` struct `{logic [ADDR_W-1:0] pc; logic [INST_W-1:0] inst;}`.
  - `fetch_state_e` enum: RUN, HALTED.
- Sub-module `fetch_buffer`: 2-entry FIFO of `fetch_entry_t` with push, pop, flush, count, head, and async active-low reset.
- The top level holds the PC, the state machine, and the redirect/HALT logic.

## Test plan
- Reset, then free run with `out_ready`=1 and ROM word0=16'h3880, word1=16'h1011:
  - Cycle 1: `out_pc`=0, `out_inst`=16'h3880.
  - Cycle 2: `out_pc`=1, `out_inst`=16'h1011.
  - `out_valid` stays 1 throughout.
- Backpressure: hold `out_ready`=0 for 5 cycles after reset.
  - `imem_addr` sticks at 2.
  - `out_pc`=0 stays stable.
  - After release, decode receives PCs 0, 1, 2, 3 on consecutive cycles.
- Wrap: redirect to 30 with a ROM containing no opcode 111.
  - Delivered PCs are 30, 31, 0, 1.
- Redirect during a stall: buffer full (PCs 4, 5), then `redirect_valid`=1 with `redirect_pc`=12.
  - Entries 4 and 5 are never delivered.
  - The next delivered entry is PC 12, one cycle later.
- HALT: ROM word 3=16'hF401 (opcode 111) and `out_ready`=1.
  - PCs 0 through 3 are delivered.
  - `halted`=1 from the cycle after PC 3 is fetched.
  - `out_valid`=0 afterwards.
  - A redirect to 0 restarts delivery at PC 0 and sets `halted`=0.
- Async reset: pull `rst_n` low between clock edges while `count`=2.
  - `out_valid`=0, `imem_addr`=RESET_PC, and `halted`=0 take effect immediately, before the next edge.
